aqed_dup_sched: RTL and testbench

AQED_DUP_SCHED -- requirements
Module: aqed_dup_sched

---
 rtl/aqed_dup_sched_if.sv | 21 ++
 rtl/aqed_dup_sched.sv | 148 ++++++++++++++
 tb/tb_aqed_dup_sched.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aqed_dup_sched_if.sv
// Memory-core port of the A-QED duplicate scheduler: write, read and status.
// master = scheduler side (drives write/read), slave = memory core side.
// Data width is fixed at 16 bits to match the host and selected-value paths.
interface aqed_dup_sched_if;
  logic        mem_wen;
  logic [15:0] mem_data_in;
  logic        mem_ren;
  logic        mem_full;
  logic        mem_valid_out;
  logic [15:0] mem_data_out;

  modport master (
    output mem_wen, mem_data_in, mem_ren,
    input  mem_full, mem_valid_out, mem_data_out
  );

  modport slave (
    input  mem_wen, mem_data_in, mem_ren,
    output mem_full, mem_valid_out, mem_data_out
  );
endinterface

// File: rtl/aqed_dup_sched.sv
// Purpose: A-QED orig/dup check: writes sel_data, gap host writes, sel_data again, reads both back, compares.
// Latency: write/read strobes are combinational; qed_done rises the cycle after the dup value is read.
// Backpressure: mem_full stalls every write (scheduler waits indefinitely); clk_en low freezes all state.
module aqed_dup_sched #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        flush,
  input  logic        start,
  input  logic [15:0] sel_data,
  input  logic [7:0]  gap,
  input  logic        host_wen,
  input  logic [15:0] host_data,
  input  logic        host_ren,
  output logic        host_ready,
  output logic        busy,
  output logic        qed_done,
  output logic        qed_mismatch,
  aqed_dup_sched_if.master mem_if
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE_ORIG = 3'd1,
    FILL       = 3'd2,
    ISSUE_DUP  = 3'd3,
    DRAIN      = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t state, nxt;

  logic [CNT_W-1:0] in_cnt, out_cnt, orig_idx, dup_idx;
  logic [7:0]       gap_cnt, gap_q;
  logic [15:0]      sel_data_q, orig_out, dup_out;
  logic             orig_got, dup_got;

  logic ctrl_issue, can_wr, rd_fire;
  logic wr_orig, wr_dup, orig_issued, dup_issued;
  logic orig_cap, dup_cap, fill_entry;

  // Write-port arbitration, read strobe and capture qualifiers.
  always_comb begin
    ctrl_issue         = (state == ISSUE_ORIG) || (state == ISSUE_DUP);
    can_wr             = ~reset & clk_en & ~flush & ~mem_if.mem_full;
    host_ready         = can_wr & ~ctrl_issue;
    mem_if.mem_wen     = can_wr & (ctrl_issue | host_wen);
    mem_if.mem_data_in = ctrl_issue ? sel_data_q : host_data;
    mem_if.mem_ren     = ~reset & clk_en & ~flush & (host_ren | (state == DRAIN));
    rd_fire            = mem_if.mem_ren & mem_if.mem_valid_out;
    wr_orig            = mem_if.mem_wen & (state == ISSUE_ORIG);
    wr_dup             = mem_if.mem_wen & (state == ISSUE_DUP);
    orig_issued        = (state == FILL) || (state == ISSUE_DUP) ||
                         (state == DRAIN) || (state == DONE);
    dup_issued         = (state == DRAIN) || (state == DONE);
    orig_cap           = rd_fire & orig_issued & ~orig_got & (out_cnt == orig_idx);
    dup_cap            = rd_fire & dup_issued & ~dup_got & (out_cnt == dup_idx);
    busy               = (state != IDLE) && (state != DONE);
    qed_mismatch       = qed_done & (orig_out != dup_out);
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    nxt = state;
    if (flush) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:       if (start) nxt = ISSUE_ORIG;
        ISSUE_ORIG: if (wr_orig) nxt = (gap_q == 8'd0) ? ISSUE_DUP : FILL;
        FILL:       if (gap_cnt == gap_q) nxt = ISSUE_DUP;
        ISSUE_DUP:  if (wr_dup) nxt = DRAIN;
        DRAIN:      if (dup_cap) nxt = DONE;
        DONE:       nxt = DONE;
        default:    nxt = IDLE;
      endcase
    end
    fill_entry = (state != FILL) && (nxt == FILL);
  end

  // State register; holds while clk_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= nxt;
    end
  end

  // Sequence counters, indices, captured values and the done flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_cnt     <= '0;
      out_cnt    <= '0;
      gap_cnt    <= '0;
      orig_idx   <= '0;
      dup_idx    <= '0;
      orig_out   <= '0;
      dup_out    <= '0;
      sel_data_q <= '0;
      gap_q      <= '0;
      orig_got   <= 1'b0;
      dup_got    <= 1'b0;
      qed_done   <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        in_cnt     <= '0;
        out_cnt    <= '0;
        gap_cnt    <= '0;
        orig_idx   <= '0;
        dup_idx    <= '0;
        orig_out   <= '0;
        dup_out    <= '0;
        sel_data_q <= '0;
        gap_q      <= '0;
        orig_got   <= 1'b0;
        dup_got    <= 1'b0;
        qed_done   <= 1'b0;
      end else begin
        if ((state == IDLE) && start) begin
          sel_data_q <= sel_data;
          gap_q      <= gap;
        end
        if (mem_if.mem_wen) in_cnt <= in_cnt + 1'b1;
        if (wr_orig) orig_idx <= in_cnt;
        if (wr_dup) dup_idx <= in_cnt;
        if (fill_entry) begin
          gap_cnt <= '0;
        end else if ((state == FILL) && mem_if.mem_wen) begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        if (rd_fire) out_cnt <= out_cnt + 1'b1;
        if (orig_cap) begin
          orig_out <= mem_if.mem_data_out;
          orig_got <= 1'b1;
        end
        if (dup_cap) begin
          dup_out <= mem_if.mem_data_out;
          dup_got <= 1'b1;
        end
        if ((nxt == DONE) && (state != DONE)) qed_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aqed_dup_sched.sv
// Bench for aqed_dup_sched: directed checks with a show-ahead FIFO memory model.
// Expected writes and completions are queued by the stimulus and consumed by a monitor.
// Directed checks cover reset, gap 0/2, backpressure, fault injection, flush and clk_en stall.
module tb_aqed_dup_sched;
  logic        clk = 1'b0;
  logic        reset, clk_en, flush, start;
  logic [15:0] sel_data, host_data;
  logic [7:0]  gap;
  logic        host_wen, host_ren;
  logic        host_ready, busy, qed_done, qed_mismatch;

  aqed_dup_sched_if m();

  aqed_dup_sched #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .start(start),
    .sel_data(sel_data), .gap(gap), .host_wen(host_wen), .host_data(host_data),
    .host_ren(host_ren), .host_ready(host_ready), .busy(busy),
    .qed_done(qed_done), .qed_mismatch(qed_mismatch), .mem_if(m)
  );

  always #5 clk = ~clk;

  // Ideal FIFO memory: head always visible, optional read-side corruption of one entry.
  logic [15:0] fifo_mem [0:63];
  int          wr_ptr, rd_ptr, corrupt_idx;
  logic        mem_clr, corrupt_en;

  assign m.mem_valid_out = (rd_ptr != wr_ptr);
  assign m.mem_data_out  = (corrupt_en && (rd_ptr == corrupt_idx)) ? 16'h0000
                                                                   : fifo_mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (reset || mem_clr) begin
      wr_ptr <= 0;
      rd_ptr <= 0;
    end else begin
      if (m.mem_wen) begin
        fifo_mem[wr_ptr[5:0]] <= m.mem_data_in;
        wr_ptr <= wr_ptr + 1;
      end
      if (m.mem_ren && m.mem_valid_out) rd_ptr <= rd_ptr + 1;
    end
  end

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_wr [$];
  logic        exp_done [$];
  int          n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (!qed_done && cyc < max) begin
      tick();
      cyc++;
    end
    if (!qed_done) chk("done_timeout", 32'(qed_done), 32'd1);
  endtask

  task automatic do_flush();
    flush   = 1'b1;
    mem_clr = 1'b1;
    tick();
    flush   = 1'b0;
    mem_clr = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] d, input logic [7:0] g);
    sel_data = d;
    gap      = g;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Scoreboard monitor: every accepted write and every qed_done rise pops an expectation.
  task automatic monitor();
    logic prev_done = 1'b0;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!reset && m.mem_wen) begin
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", 32'(m.mem_wen), 32'd0);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_data", 32'(m.mem_data_in), 32'(e));
        end
      end
      if (qed_done && !prev_done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 32'(qed_done), 32'd0);
        else chk("mismatch", 32'(qed_mismatch), 32'(exp_done.pop_front()));
      end
      prev_done = qed_done;
    end
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0; start = 1'b0;
    host_wen = 1'b1; host_ren = 1'b1; host_data = 16'hBEEF;
    sel_data = 16'h0; gap = 8'd0; m.mem_full = 1'b0;
    mem_clr = 1'b0; corrupt_en = 1'b0; corrupt_idx = 0;
    fork monitor(); join_none

    // Reset: host requests are active but nothing may be issued.
    repeat (2) @(posedge clk);
    smp();
    chk("rst_mem_wen", 32'(m.mem_wen), 32'd0);
    chk("rst_mem_ren", 32'(m.mem_ren), 32'd0);
    chk("rst_host_ready", 32'(host_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_qed_done", 32'(qed_done), 32'd0);
    chk("rst_mismatch", 32'(qed_mismatch), 32'd0);
    tick();
    reset = 1'b0; host_wen = 1'b0; host_ren = 1'b0;
    tick();

    // Basic: gap=2, orig at 0, host writes at 1,2, dup at 3.
    exp_wr.push_back(16'hA5A5); exp_wr.push_back(16'h0001);
    exp_wr.push_back(16'h0002); exp_wr.push_back(16'hA5A5);
    exp_done.push_back(1'b0);
    do_start(16'hA5A5, 8'd2);
    chk("basic_issue_orig", 32'(dut.state), 32'd1);
    chk("basic_busy", 32'(busy), 32'd1);
    tick();
    chk("basic_fill", 32'(dut.state), 32'd2);
    host_wen = 1'b1; host_data = 16'h0001;
    tick();
    host_data = 16'h0002;
    tick();
    host_wen = 1'b0;
    wait_done(30, n);
    chk("basic_orig_idx", 32'(dut.orig_idx), 32'd0);
    chk("basic_dup_idx", 32'(dut.dup_idx), 32'd3);
    chk("basic_wr_count", 32'(wr_ptr), 32'd4);
    chk("basic_mem3", 32'(fifo_mem[3]), 32'h0000_A5A5);
    chk("basic_state_done", 32'(dut.state), 32'd5);
    tick();
    chk("basic_done_held", 32'(qed_done), 32'd1);
    chk("basic_not_busy", 32'(busy), 32'd0);
    do_flush();

    // Zero gap: orig and dup on consecutive accepted cycles.
    exp_wr.push_back(16'h3C3C); exp_wr.push_back(16'h3C3C);
    exp_done.push_back(1'b0);
    do_start(16'h3C3C, 8'd0);
    tick();
    chk("zg_issue_dup", 32'(dut.state), 32'd3);
    smp();
    chk("zg_dup_wen", 32'(m.mem_wen), 32'd1);
    tick();
    chk("zg_drain", 32'(dut.state), 32'd4);
    wait_done(30, n);
    chk("zg_drain_cycles", 32'(n), 32'd2);
    chk("zg_orig_idx", 32'(dut.orig_idx), 32'd0);
    chk("zg_dup_idx", 32'(dut.dup_idx), 32'd1);
    do_flush();

    // Backpressure: mem_full for 5 cycles in ISSUE_DUP.
    exp_wr.push_back(16'h1234); exp_wr.push_back(16'h1234);
    exp_done.push_back(1'b0);
    do_start(16'h1234, 8'd0);
    tick();
    m.mem_full = 1'b1; host_wen = 1'b1; host_data = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("bp_mem_wen", 32'(m.mem_wen), 32'd0);
      chk("bp_host_ready", 32'(host_ready), 32'd0);
      chk("bp_state", 32'(dut.state), 32'd3);
      tick();
    end
    m.mem_full = 1'b0; host_wen = 1'b0;
    smp();
    chk("bp_release_wen", 32'(m.mem_wen), 32'd1);
    tick();
    chk("bp_drain", 32'(dut.state), 32'd4);
    wait_done(30, n);
    chk("bp_dup_idx", 32'(dut.dup_idx), 32'd1);
    do_flush();

    // Fault injection: entry at dup_idx (2) reads back as zero.
    corrupt_en = 1'b1; corrupt_idx = 2;
    exp_wr.push_back(16'h5A5A); exp_wr.push_back(16'h0077); exp_wr.push_back(16'h5A5A);
    exp_done.push_back(1'b1);
    do_start(16'h5A5A, 8'd1);
    tick();
    host_wen = 1'b1; host_data = 16'h0077;
    tick();
    host_wen = 1'b0;
    wait_done(30, n);
    chk("fault_dup_idx", 32'(dut.dup_idx), 32'd2);
    chk("fault_mismatch", 32'(qed_mismatch), 32'd1);
    do_flush();
    corrupt_en = 1'b0;

    // Flush in FILL after one host write, then a fresh check.
    exp_wr.push_back(16'h0F0F); exp_wr.push_back(16'h0011);
    do_start(16'h0F0F, 8'd3);
    tick();
    host_wen = 1'b1; host_data = 16'h0011;
    tick();
    host_data = 16'h0022; host_ren = 1'b1; flush = 1'b1; mem_clr = 1'b1;
    smp();
    chk("flush_no_wen", 32'(m.mem_wen), 32'd0);
    chk("flush_no_ren", 32'(m.mem_ren), 32'd0);
    tick();
    flush = 1'b0; mem_clr = 1'b0; host_wen = 1'b0; host_ren = 1'b0;
    chk("flush_idle", 32'(dut.state), 32'd0);
    chk("flush_in_cnt", 32'(dut.in_cnt), 32'd0);
    chk("flush_qed_done", 32'(qed_done), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    exp_wr.push_back(16'hC3C3); exp_wr.push_back(16'hC3C3);
    exp_done.push_back(1'b0);
    do_start(16'hC3C3, 8'd0);
    wait_done(30, n);
    chk("reflush_dup_idx", 32'(dut.dup_idx), 32'd1);
    do_flush();

    // clk_en low for 3 cycles in DRAIN: 3 start/issue ticks + 3 stalled + 2 drain = 8.
    exp_wr.push_back(16'h6666); exp_wr.push_back(16'h6666);
    exp_done.push_back(1'b0);
    do_start(16'h6666, 8'd0);
    tick();
    tick();
    chk("ce_drain", 32'(dut.state), 32'd4);
    clk_en = 1'b0; host_wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("ce_no_ren", 32'(m.mem_ren), 32'd0);
      chk("ce_no_ready", 32'(host_ready), 32'd0);
      chk("ce_out_cnt", 32'(dut.out_cnt), 32'd0);
      chk("ce_state", 32'(dut.state), 32'd4);
      tick();
    end
    clk_en = 1'b1; host_wen = 1'b0;
    wait_done(30, n);
    chk("ce_total_cycles", 32'(3 + 3 + n), 32'd8);

    repeat (3) tick();
    chk("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
    chk("sb_done_empty", 32'(exp_done.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
